// File: rtl/spike_isi_monitor.sv
// spike_isi_monitor: turns a neuron spike train into a per-window spike rate and
// a stream of inter-spike intervals (ISI) on a valid/ready handshake.
// Optional build macro SPIKE_MON_PEAK_EN adds a per-window peak membrane state output.
// All outputs are registered; reset is synchronous and active-high.

module spike_isi_monitor #(
    parameter int unsigned WINDOW = 256,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned ISI_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike,
    input  logic [7:0]       state,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic [ISI_W-1:0] isi_data,
    output logic             isi_valid,
    input  logic             isi_ready,
    output logic             isi_ovf
`ifdef SPIKE_MON_PEAK_EN
    ,
    output logic [7:0]       peak
`endif
);

    localparam int unsigned      WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};

    typedef enum logic [0:0] {
        StIdle,
        StArmed
    } isi_state_e;

    // ------------------------------------------------------------------
    // Onset detection
    // ------------------------------------------------------------------
    logic spike_q;
    logic onset;

    // Previous spike level, sampled regardless of enable so a spike held
    // across an enable edge is not mistaken for a fresh onset.
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike;
        end
    end

    assign onset = spike & ~spike_q & en;

    // ------------------------------------------------------------------
    // Rate path
    // ------------------------------------------------------------------
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] spk_q, spk_d;
    logic [CNT_W-1:0] spk_inc;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             rate_valid_q, rate_valid_d;
    logic             win_last;

    assign win_last = en && (win_q == WIN_LAST);
    assign spk_inc  = (spk_q == CNT_MAX) ? spk_q : spk_q + CNT_W'(1);

    // Window counter, saturating spike counter and rate publication.
    always_comb begin
        win_d        = win_q;
        spk_d        = spk_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;
        if (en) begin
            win_d = win_last ? '0 : win_q + WIN_W'(1);
        end
        if (win_last) begin
            // An onset in the closing cycle still belongs to this window.
            rate_d       = onset ? spk_inc : spk_q;
            rate_valid_d = 1'b1;
            spk_d        = '0;
        end else if (onset) begin
            spk_d = spk_inc;
        end
    end

    // Rate path state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q        <= '0;
            spk_q        <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            win_q        <= win_d;
            spk_q        <= spk_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
        end
    end

    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;

    // ------------------------------------------------------------------
    // ISI measurement state machine
    // ------------------------------------------------------------------
    isi_state_e       isi_st_q, isi_st_d;
    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
    logic             cand_vld;

    // Next-state logic: the first onset only arms; later onsets emit a candidate.
    always_comb begin
        isi_st_d  = isi_st_q;
        isi_cnt_d = isi_cnt_q;
        cand_vld  = 1'b0;
        case (isi_st_q)
            StIdle: begin
                if (onset) begin
                    isi_st_d  = StArmed;
                    isi_cnt_d = ISI_W'(1);
                end
            end
            StArmed: begin
                if (onset) begin
                    cand_vld  = 1'b1;
                    isi_cnt_d = ISI_W'(1);
                end else if (en && (isi_cnt_q != ISI_MAX)) begin
                    isi_cnt_d = isi_cnt_q + ISI_W'(1);
                end
            end
            default: begin
                isi_st_d  = StIdle;
                isi_cnt_d = '0;
            end
        endcase
    end

    // ISI state machine register.
    always_ff @(posedge clk) begin
        if (rst) begin
            isi_st_q  <= StIdle;
            isi_cnt_q <= '0;
        end else begin
            isi_st_q  <= isi_st_d;
            isi_cnt_q <= isi_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Single-entry ISI output buffer
    // ------------------------------------------------------------------
    logic [ISI_W-1:0] isi_data_q, isi_data_d;
    logic             isi_valid_q, isi_valid_d;
    logic             isi_ovf_q, isi_ovf_d;
    logic             xfer;
    logic             load;

    assign xfer = isi_valid_q & isi_ready;
    // Buffer accepts a candidate when empty or when its current entry leaves now.
    assign load = cand_vld & (~isi_valid_q | isi_ready);

    // Buffer next-state: load wins over drain; a refused candidate raises overflow.
    always_comb begin
        isi_data_d  = isi_data_q;
        isi_valid_d = isi_valid_q;
        isi_ovf_d   = isi_ovf_q;
        if (load) begin
            isi_data_d  = isi_cnt_q;
            isi_valid_d = 1'b1;
        end else begin
            if (xfer) begin
                isi_valid_d = 1'b0;
            end
            if (cand_vld) begin
                isi_ovf_d = 1'b1;
            end
        end
    end

    // Output buffer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            isi_data_q  <= '0;
            isi_valid_q <= 1'b0;
            isi_ovf_q   <= 1'b0;
        end else begin
            isi_data_q  <= isi_data_d;
            isi_valid_q <= isi_valid_d;
            isi_ovf_q   <= isi_ovf_d;
        end
    end

    assign isi_data  = isi_data_q;
    assign isi_valid = isi_valid_q;
    assign isi_ovf   = isi_ovf_q;

    // ------------------------------------------------------------------
    // Optional per-window peak of the membrane state
    // ------------------------------------------------------------------
`ifdef SPIKE_MON_PEAK_EN
    logic [7:0] peak_run_q, peak_run_d;
    logic [7:0] peak_q, peak_d;
    logic [7:0] state_max;

    assign state_max = (state > peak_run_q) ? state : peak_run_q;

    // Running maximum over enabled cycles, published with the rate.
    always_comb begin
        peak_run_d = peak_run_q;
        peak_d     = peak_q;
        if (win_last) begin
            peak_d     = state_max;
            peak_run_d = '0;
        end else if (en) begin
            peak_run_d = state_max;
        end
    end

    // Peak tracking register.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_run_q <= '0;
            peak_q     <= '0;
        end else begin
            peak_run_q <= peak_run_d;
            peak_q     <= peak_d;
        end
    end

    assign peak = peak_q;
`else
    // Membrane state is only consumed by the peak tracker.
    logic unused_state;
    assign unused_state = ^state;
`endif

endmodule
